// File: rtl/uart_tx_fifo_drain.sv
// Byte FIFO between the response logic and txuart; drains one byte at a time
// through the txuart valid/busy handshake, with pause and overflow reporting.
module uart_tx_fifo_drain #(
    parameter int unsigned FIFO_DEPTH = 64,
    parameter int unsigned ADDR_WIDTH = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [7:0]            wr_data,
    input  logic                  wr_en,
    input  logic                  tx_pause,
    output logic                  fifo_full,
    output logic                  fifo_empty,
    output logic [ADDR_WIDTH:0]   data_count,
    output logic                  overflow,
    output logic [7:0]            tx_uart_data,
    output logic                  tx_uart_valid,
    input  logic                  tx_uart_busy,
    output logic                  tx_idle
);

    localparam int unsigned CW = ADDR_WIDTH + 1;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        SEND  = 3'd2,
        HOLD  = 3'd3,
        DRAIN = 3'd4
    } state_t;

    state_t                state;
    logic [7:0]            mem [FIFO_DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic [7:0]            dout;

    logic                  wr_ok_c;
    logic                  pop_c;
    logic                  idle_next_c;
    logic [CW-1:0]         count_next_c;

    // Fullness is judged before any same-cycle pop, so a write to a full FIFO is always dropped.
    assign wr_ok_c = wr_en && !fifo_full;
    assign pop_c   = (state == IDLE) && !fifo_empty && !tx_pause;

    always_comb begin
        count_next_c = data_count;
        if (wr_ok_c && !pop_c) begin
            count_next_c = data_count + CW'(1);
        end else if (!wr_ok_c && pop_c) begin
            count_next_c = data_count - CW'(1);
        end
    end

    // Idle next cycle: nothing stored, FSM settling in IDLE, txuart not busy.
    assign idle_next_c = (count_next_c == '0) && !tx_uart_busy &&
                         ((state == DRAIN) || ((state == IDLE) && !pop_c));

    always_ff @(posedge clk) begin
        if (!rst && wr_ok_c) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // FIFO pointers, occupancy, flags and registered read port.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            data_count <= '0;
            fifo_empty <= 1'b1;
            fifo_full  <= 1'b0;
            overflow   <= 1'b0;
            dout       <= 8'h00;
        end else begin
            if (wr_ok_c) begin
                wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
            end
            if (pop_c) begin
                rd_ptr <= rd_ptr + ADDR_WIDTH'(1);
                dout   <= mem[rd_ptr];
            end
            data_count <= count_next_c;
            fifo_empty <= (count_next_c == '0);
            fifo_full  <= (count_next_c == CW'(FIFO_DEPTH));
            overflow   <= wr_en && fifo_full;
        end
    end

    // Drain FSM: one byte in flight; HOLD skips the busy sample that predates acceptance.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            tx_uart_valid <= 1'b0;
            tx_uart_data  <= 8'h00;
            tx_idle       <= 1'b1;
        end else begin
            tx_idle <= idle_next_c;
            case (state)
                IDLE: begin
                    if (pop_c) begin
                        state <= LOAD;
                    end
                end
                LOAD: begin
                    tx_uart_data  <= dout;
                    tx_uart_valid <= 1'b1;
                    state         <= SEND;
                end
                SEND: begin
                    if (!tx_uart_busy) begin
                        tx_uart_valid <= 1'b0;
                        state         <= HOLD;
                    end
                end
                HOLD: begin
                    state <= DRAIN;
                end
                DRAIN: begin
                    if (!tx_uart_busy) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo_drain.sv
// Bench for uart_tx_fifo_drain: queue-based byte model, txuart busy model,
// per-cycle invariant checks plus directed literal expectations.
module tb_uart_tx_fifo_drain;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] wr_data;
    logic       wr_en;
    logic       tx_pause;
    logic       fifo_full;
    logic       fifo_empty;
    logic [6:0] data_count;
    logic       overflow;
    logic [7:0] tx_uart_data;
    logic       tx_uart_valid;
    logic       tx_uart_busy;
    logic       tx_idle;

    logic       ext_busy;
    int         frame_len;
    int         busy_cnt = 0;

    int         n_cmp = 0;
    int         n_bad = 0;

    logic [7:0] q[$];
    int         n_wr = 0;
    int         n_acc = 0;
    logic       exp_ovf = 1'b0;
    logic       rst_q = 1'b0;
    logic       started = 1'b0;

    always #5 clk = ~clk;

    uart_tx_fifo_drain #(.FIFO_DEPTH(64), .ADDR_WIDTH(6)) dut (
        .clk           (clk),
        .rst           (rst),
        .wr_data       (wr_data),
        .wr_en         (wr_en),
        .tx_pause      (tx_pause),
        .fifo_full     (fifo_full),
        .fifo_empty    (fifo_empty),
        .data_count    (data_count),
        .overflow      (overflow),
        .tx_uart_data  (tx_uart_data),
        .tx_uart_valid (tx_uart_valid),
        .tx_uart_busy  (tx_uart_busy),
        .tx_idle       (tx_idle)
    );

    assign tx_uart_busy = ext_busy || (busy_cnt != 0);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // txuart stand-in: busy for frame_len cycles starting the cycle after an accept.
    always @(posedge clk) begin
        if (rst) busy_cnt <= 0;
        else if (tx_uart_valid && !tx_uart_busy) busy_cnt <= frame_len;
        else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
    end

    // Byte-level model: accepted writes queue up, every txuart accept must take the oldest.
    always @(posedge clk) begin
        rst_q   = rst;
        started = 1'b1;
        exp_ovf = 1'b0;
        if (rst) begin
            q.delete();
            n_wr  = 0;
            n_acc = 0;
        end else begin
            if (wr_en) begin
                if ((n_wr - n_acc) >= 64) exp_ovf = 1'b1;
                else begin
                    q.push_back(wr_data);
                    n_wr++;
                end
            end
            if (tx_uart_valid && !tx_uart_busy) begin
                if (q.size() == 0) chk("accept_with_nothing_written", 32'd1, 32'd0);
                else chk("tx_byte_order", 32'(tx_uart_data), 32'(q.pop_front()));
                n_acc++;
            end
        end
    end

    // Per-cycle compare against the model.
    logic       prev_valid = 1'b0;
    logic [7:0] prev_data = 8'h00;
    int         prev_acc = 0;
    always @(negedge clk) begin : cmp
        int stored;
        if (started) begin
            if (rst_q) begin
                chk("rst_fifo_empty", 32'(fifo_empty), 32'd1);
                chk("rst_fifo_full", 32'(fifo_full), 32'd0);
                chk("rst_data_count", 32'(data_count), 32'd0);
                chk("rst_overflow", 32'(overflow), 32'd0);
                chk("rst_valid", 32'(tx_uart_valid), 32'd0);
                chk("rst_data", 32'(tx_uart_data), 32'd0);
                chk("rst_tx_idle", 32'(tx_idle), 32'd1);
            end else begin
                stored = n_wr - n_acc;
                if (tx_uart_valid) begin
                    chk("valid_needs_pending_byte", 32'(stored >= 1), 32'd1);
                    chk("count_with_byte_in_flight", 32'(data_count), 32'(stored - 1));
                end else begin
                    n_cmp++;
                    if (!((int'(data_count) == stored) ||
                          (stored > 0 && int'(data_count) == stored - 1))) begin
                        n_bad++;
                        $display("FAIL count_window: got %0d, expected %0d or %0d (t=%0t)",
                                 data_count, stored, stored - 1, $time);
                    end
                end
                if (stored == 0) chk("empty_when_nothing_stored", 32'(fifo_empty), 32'd1);
                if (stored >= 2) chk("not_empty_when_two_stored", 32'(fifo_empty), 32'd0);
                if (stored < 64) chk("not_full_below_depth", 32'(fifo_full), 32'd0);
                chk("overflow_pulse", 32'(overflow), 32'(exp_ovf));
                if (prev_valid && tx_uart_valid && prev_acc == n_acc)
                    chk("data_stable_while_valid", 32'(tx_uart_data), 32'(prev_data));
            end
            prev_valid = tx_uart_valid;
            prev_data  = tx_uart_data;
            prev_acc   = n_acc;
        end
    end

    task automatic wait_acc(input int target, input int budget, input string name);
        int k;
        k = 0;
        while (n_acc < target && k < budget) begin
            @(negedge clk);
            k++;
        end
        chk(name, 32'(n_acc), 32'(target));
    endtask

    task automatic wait_quiet(input string name);
        int k;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!(tx_idle && n_wr == n_acc && !tx_uart_busy) && k < 3000);
        chk(name, 32'(tx_idle), 32'd1);
    endtask

    task automatic wait_valid(input string name);
        int k;
        k = 0;
        while (!tx_uart_valid && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk(name, 32'(tx_uart_valid), 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: run exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int k;
        wr_en = 1'b0; wr_data = 8'h00; tx_pause = 1'b0; ext_busy = 1'b0;
        frame_len = 100; rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("init_tx_idle", 32'(tx_idle), 32'd1);
        chk("init_empty", 32'(fifo_empty), 32'd1);

        // Single byte: valid two cycles after non-empty is seen in IDLE.
        wr_en = 1'b1; wr_data = 8'hA5;
        @(negedge clk); wr_en = 1'b0;
        chk("single_nonempty", 32'(fifo_empty), 32'd0);
        chk("single_valid_c1", 32'(tx_uart_valid), 32'd0);
        @(negedge clk);
        chk("single_valid_c2", 32'(tx_uart_valid), 32'd0);
        @(negedge clk);
        chk("single_valid_c3", 32'(tx_uart_valid), 32'd1);
        chk("single_data", 32'(tx_uart_data), 32'hA5);
        k = 0;
        do begin @(negedge clk); k++; end while (tx_uart_busy && k < 300);
        repeat (2) @(negedge clk);
        chk("single_idle_after_busy", 32'(tx_idle), 32'd1);
        chk("single_one_accept", 32'(n_acc), 32'd1);

        // Write and pop in the same cycle with one byte stored.
        wr_en = 1'b1; wr_data = 8'h11;
        @(negedge clk); wr_data = 8'h22;
        chk("simul_count_before", 32'(data_count), 32'd1);
        @(negedge clk); wr_en = 1'b0;
        chk("simul_count_held", 32'(data_count), 32'd1);
        chk("simul_not_empty", 32'(fifo_empty), 32'd0);
        wait_acc(3, 600, "simul_both_sent");
        wait_quiet("simul_quiet");

        // Busy stall: txuart busy before LOAD keeps the FSM in SEND.
        frame_len = 10;
        ext_busy = 1'b1;
        wr_en = 1'b1; wr_data = 8'h3C;
        @(negedge clk); wr_en = 1'b0;
        wait_valid("stall_valid_up");
        repeat (20) begin
            @(negedge clk);
            chk("stall_valid_held", 32'(tx_uart_valid), 32'd1);
            chk("stall_data_held", 32'(tx_uart_data), 32'h3C);
        end
        base = n_acc;
        ext_busy = 1'b0;
        @(negedge clk);
        chk("stall_accept_first_free", 32'(n_acc), 32'(base + 1));
        chk("stall_valid_drops", 32'(tx_uart_valid), 32'd0);
        wait_quiet("stall_quiet");

        // Burst of 80 bytes crossing the pointer wrap, paced below full.
        frame_len = 4;
        base = n_acc;
        for (int i = 0; i < 80; i++) begin
            k = 0;
            while ((n_wr - n_acc) >= 60 && k < 1000) begin @(negedge clk); k++; end
            wr_en = 1'b1; wr_data = 8'(i);
            @(negedge clk); wr_en = 1'b0;
            @(negedge clk);
        end
        wait_acc(base + 80, 5000, "burst_all_sent");
        wait_quiet("burst_quiet");
        chk("burst_count_zero", 32'(data_count), 32'd0);
        chk("burst_empty", 32'(fifo_empty), 32'd1);

        // Fill while paused, one overflow, then drain exactly 64.
        tx_pause = 1'b1;
        for (int i = 0; i < 65; i++) begin
            wr_en = 1'b1; wr_data = 8'(128 + i);
            @(negedge clk);
            if (i == 62) begin
                chk("full_not_yet_63", 32'(fifo_full), 32'd0);
                chk("count_63", 32'(data_count), 32'd63);
            end
            if (i == 63) begin
                chk("full_at_64", 32'(fifo_full), 32'd1);
                chk("count_64", 32'(data_count), 32'd64);
            end
            if (i == 64) begin
                chk("overflow_on_65th", 32'(overflow), 32'd1);
                chk("count_stays_64", 32'(data_count), 32'd64);
            end
        end
        wr_en = 1'b0;
        @(negedge clk);
        chk("overflow_one_cycle", 32'(overflow), 32'd0);
        chk("paused_no_valid", 32'(tx_uart_valid), 32'd0);
        base = n_acc;
        tx_pause = 1'b0;
        wait_acc(base + 64, 3000, "full_drain_64");
        wait_quiet("full_quiet");
        repeat (30) @(negedge clk);
        chk("full_exactly_64", 32'(n_acc - base), 32'd64);
        chk("full_count_zero", 32'(data_count), 32'd0);

        // Reset while the FSM is stalled in SEND abandons everything.
        ext_busy = 1'b1;
        wr_en = 1'b1; wr_data = 8'h55;
        @(negedge clk); wr_data = 8'h66;
        @(negedge clk); wr_en = 1'b0;
        wait_valid("rstmid_in_send");
        rst = 1'b1; ext_busy = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rstmid_valid", 32'(tx_uart_valid), 32'd0);
        chk("rstmid_count", 32'(data_count), 32'd0);
        chk("rstmid_empty", 32'(fifo_empty), 32'd1);
        chk("rstmid_idle", 32'(tx_idle), 32'd1);
        repeat (100) @(negedge clk);
        chk("rstmid_no_more_bytes", 32'(n_acc), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
